// File: rtl/tone_pdm_tx.sv
// ============================================================================
// tone_pdm_tx
// ----------------------------------------------------------------------------
// One-shot square-wave tone generator for the mono audio amplifier. When a
// start request arrives it plays a square wave for a programmed number of PDM
// bits. Each bit comes from a first-order sigma-delta modulator and is held
// for CLK_DIV system clocks. A one-cycle done pulse marks normal completion.
//
// Parameters:
//   CLK_DIV  system clocks per PDM bit (>= 2)
//   HP_W     width of the half-period input
//   DUR_W    width of the duration input
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   start_i        play request, sampled only while idle
//   half_period_i  tone half-period in PDM ticks (0 behaves as 1)
//   duration_i     tone length in PDM bits
//   amplitude_i    unsigned level used during the high phase
//   abort_i        stop playback on the next cycle, no done pulse
//   busy_o         high while a tone is playing
//   done_o         one-cycle pulse on normal completion
//   pdm_o          PDM bitstream (0 while idle)
//   sd_o           amplifier enable (high while playing)
// ============================================================================
module tone_pdm_tx #(
    parameter int CLK_DIV = 40,
    parameter int HP_W    = 16,
    parameter int DUR_W   = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [HP_W-1:0]  half_period_i,
    input  logic [DUR_W-1:0] duration_i,
    input  logic [7:0]       amplitude_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pdm_o,
    output logic             sd_o
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_done_set;

    logic [TW-1:0]     r_tick_cnt;
    logic [HP_W-1:0]   r_hp;
    logic [HP_W-1:0]   r_hp_cnt;
    logic [DUR_W-1:0]  r_dur_cnt;
    logic [7:0]        r_amp;
    logic [7:0]        r_acc;
    logic              r_phase;
    logic              r_pdm;
    logic              r_done;

    logic              w_tick;
    logic              w_dur_zero;
    logic              w_hp_wrap;
    logic [7:0]        w_sample;
    logic [8:0]        w_sum;

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_dur_zero = (r_dur_cnt == '0);
    assign w_hp_wrap  = (r_hp_cnt == (r_hp - HP_W'(1)));
    assign w_sample   = r_phase ? r_amp : 8'd0;
    // The carry out of the accumulator is the emitted bit, so the long-run
    // density of ones is sample/256.
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_sample};

    // Next-state logic. Abort takes priority over the end-of-tone tick so an
    // aborted tone never produces a done pulse.
    always_comb begin
        w_next_state = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = PLAY;
                end
            end
            PLAY: begin
                if (abort_i) begin
                    w_next_state = IDLE;
                end else if (w_tick && w_dur_zero) begin
                    w_next_state = IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and datapath. The counters freeze while idle. The tone
    // parameters are latched on acceptance, so inputs can change freely
    // during playback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_tick_cnt <= '0;
            r_hp       <= '0;
            r_hp_cnt   <= '0;
            r_dur_cnt  <= '0;
            r_amp      <= '0;
            r_acc      <= '0;
            r_phase    <= 1'b0;
            r_pdm      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_set;
            case (r_state)
                IDLE: begin
                    r_pdm <= 1'b0;
                    if (start_i) begin
                        r_hp       <= (half_period_i == '0) ? HP_W'(1) : half_period_i;
                        r_dur_cnt  <= duration_i;
                        r_amp      <= amplitude_i;
                        r_tick_cnt <= '0;
                        r_hp_cnt   <= '0;
                        r_acc      <= '0;
                        r_phase    <= 1'b1;
                    end
                end
                PLAY: begin
                    if (abort_i) begin
                        r_pdm <= 1'b0;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                        if (w_tick) begin
                            if (w_dur_zero) begin
                                // Completion tick: no bit is emitted and the line returns low.
                                r_pdm <= 1'b0;
                            end else begin
                                r_pdm     <= w_sum[8];
                                r_acc     <= w_sum[7:0];
                                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                                if (w_hp_wrap) begin
                                    r_hp_cnt <= '0;
                                    r_phase  <= ~r_phase;
                                end else begin
                                    r_hp_cnt <= r_hp_cnt + HP_W'(1);
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_pdm <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (r_state == PLAY);
    assign sd_o   = (r_state == PLAY);
    assign done_o = r_done;
    assign pdm_o  = r_pdm;

endmodule

// File: tb/tb_tone_pdm_tx.sv
// ============================================================================
// tb_tone_pdm_tx
// ----------------------------------------------------------------------------
// Self-checking bench for tone_pdm_tx with CLK_DIV = 4. A behavioural model
// tracks each accepted tone. Every PDM bit comes from the cumulative sample
// sum crossing a multiple of 256. A compare process checks all outputs at each
// falling edge. Directed scenarios add literal expectations for bit patterns,
// tone length and done timing.
// ============================================================================
module tb_tone_pdm_tx;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] hp;
    logic [23:0] dur;
    logic [7:0]  amp;
    logic        busy;
    logic        done;
    logic        pdm;
    logic        sd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tone_pdm_tx #(
        .CLK_DIV(D),
        .HP_W   (16),
        .DUR_W  (24)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .half_period_i(hp),
        .duration_i   (dur),
        .amplitude_i  (amp),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .pdm_o        (pdm),
        .sd_o         (sd)
    );

    // Single place where comparisons are counted and failures reported.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Bit j (0-based) of a tone is 1 when the running sum of samples crosses
    // a multiple of 256. The square wave is high during even half-periods.
    function automatic bit modelBit(input int j, input int hpv, input int ampv);
        int h;
        int s;
        int sPrev;
        h     = (hpv == 0) ? 1 : hpv;
        s     = 0;
        sPrev = 0;
        for (int i = 0; i <= j; i++) begin
            sPrev = s;
            s     = s + ((((i / h) % 2) == 0) ? ampv : 0);
        end
        return (s / 256) != (sPrev / 256);
    endfunction

    function automatic logic [31:0] modelVec(input int hpv, input int n, input int ampv);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < n && j < 32; j++) begin
            v[j] = modelBit(j, hpv, ampv);
        end
        return v;
    endfunction

    // Behavioural model: tone start edge, length and precomputed bits.
    int edgeCnt   = 0;
    bit mActive   = 1'b0;
    int mT        = 0;
    int mN        = 0;
    int mDoneEdge = -1;
    bit mBits [0:255];

    always @(posedge clk) begin
        edgeCnt++;
        if (rst) begin
            mActive = 1'b0;
        end else if (mActive) begin
            if (abort) begin
                mActive = 1'b0;
            end else if (edgeCnt - mT == (mN + 1) * D) begin
                mActive   = 1'b0;
                mDoneEdge = edgeCnt;
            end
        end else if (start) begin
            mActive = 1'b1;
            mT      = edgeCnt;
            mN      = int'(dur);
            for (int j = 0; j < mN && j < 256; j++) begin
                mBits[j] = modelBit(j, int'(hp), int'(amp));
            end
        end
    end

    logic expBusy;
    logic expDone;
    logic expPdm;
    int   expD;

    // Compare all outputs with the model at each falling edge.
    always @(negedge clk) begin
        if (edgeCnt > 0) begin
            if (mActive) begin
                expD    = edgeCnt - mT;
                expBusy = 1'b1;
                expDone = 1'b0;
                expPdm  = (expD >= D) ? mBits[expD / D - 1] : 1'b0;
            end else begin
                expBusy = 1'b0;
                expPdm  = 1'b0;
                expDone = (mDoneEdge == edgeCnt);
            end
            checkOutput("cycle{busy,sd,done,pdm}", {28'd0, busy, sd, done, pdm},
                        {28'd0, expBusy, expBusy, expDone, expPdm});
        end
    end

    // Start one tone, then garble the inputs. Sample each bit mid-window and
    // check the bit pattern, done timing and busy length.
    task automatic applyStimulus(input string name, input logic [15:0] h, input logic [23:0] n,
                                 input logic [7:0] a, input logic [31:0] expBits);
        int          doneAt;
        int          busyCnt;
        logic [31:0] got;
        @(negedge clk);
        hp    = h;
        dur   = n;
        amp   = a;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        hp      = 16'd7;
        dur     = 24'd1000;
        amp     = 8'd3;
        doneAt  = -1;
        busyCnt = 0;
        got     = '0;
        for (int i = 0; i < 400 && doneAt < 0; i++) begin
            if (busy) busyCnt++;
            if (i >= D && (i % D) == D / 2 && (i / D - 1) < 32) got[i / D - 1] = pdm;
            if (done) doneAt = i;
            if (doneAt < 0) @(negedge clk);
        end
        checkOutput({name, "_bits"}, got, expBits);
        checkOutput({name, "_done_at"}, doneAt, (int'(n) + 1) * D);
        checkOutput({name, "_busy_len"}, busyCnt, (int'(n) + 1) * D);
    endtask

    int bc;
    bit seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        hp    = '0;
        dur   = '0;
        amp   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {28'd0, busy, sd, done, pdm}, 32'd0);
        rst = 1'b0;

        // Pin the model itself against hand-derived patterns.
        checkOutput("model_full", modelVec(2, 8, 255), 32'b00110010);
        checkOutput("model_half", modelVec(100, 8, 128), 32'b10101010);
        checkOutput("model_hp0", modelVec(0, 4, 255), 32'b0100);

        applyStimulus("full", 16'd2, 24'd8, 8'd255, 32'b00110010);
        applyStimulus("half", 16'd100, 24'd8, 8'd128, 32'b10101010);
        applyStimulus("dur0", 16'd5, 24'd0, 8'd200, 32'b0);
        applyStimulus("hp0", 16'd0, 24'd4, 8'd255, 32'b0100);

        // Abort at bit 3 while start stays high the whole time.
        @(negedge clk);
        hp    = 16'd2;
        dur   = 24'd8;
        amp   = 8'd255;
        start = 1'b1;
        repeat (3 * D + 2) @(negedge clk);
        checkOutput("abort_pre_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle", {28'd0, busy, sd, done, pdm}, 32'd0);
        abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        end

        // Reset mid-play, then a normal tone afterwards.
        @(negedge clk);
        hp    = 16'd2;
        dur   = 24'd8;
        amp   = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid", {28'd0, busy, sd, done, pdm}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_hold", {28'd0, busy, sd, done, pdm}, 32'd0);
        applyStimulus("after_rst", 16'd3, 24'd6, 8'd255, 32'b000110);

        // Back-to-back: the second start is driven during the done cycle.
        @(negedge clk);
        hp    = 16'd1;
        dur   = 24'd2;
        amp   = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc    = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (busy) bc++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("b2b_first_done", {31'd0, seen}, 32'd1);
        checkOutput("b2b_first_len", bc, 3 * D);
        checkOutput("b2b_gap", {31'd0, busy}, 32'd0);
        hp    = 16'd2;
        dur   = 24'd3;
        amp   = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_second_busy", {31'd0, busy}, 32'd1);
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (busy) bc++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("b2b_second_done", {31'd0, seen}, 32'd1);
        checkOutput("b2b_second_len", bc, 4 * D);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_pdm_tx.md
# tone_pdm_tx

Audio-output counterpart of the PDM microphone path: a one-shot tone generator that drives the board's mono audio amplifier (AUD_PWM / AUD_SD) with a first-order sigma-delta (PDM) bitstream. On a start request it plays a square-wave tone for a programmed duration, then signals completion. It sits beside the clap-detection logic in the top level. The state/display logic triggers it, for example a confirmation beep on a detected clap or a button press.

## Interface
Parameters:
- CLK_DIV, 40: system clocks per PDM bit. 100 MHz / 40 gives 2.5 MHz, the same rate as the microphone clock. Must be ≥ 2.
- HP_W, 16: width of the half-period input.
- DUR_W, 24: width of the duration input.

Ports:
- clk_i  in  1  system clock (CLK100MHZ)
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  play request; sampled only in IDLE
- half_period_i  in  HP_W  tone half-period in PDM ticks; 0 is treated as 1
- duration_i  in  DUR_W  tone length in PDM bits
- amplitude_i  in  8  unsigned level for the tone's high phase
- abort_i  in  1  stop playback immediately
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle pulse on normal completion
- pdm_o  out  1  PDM bitstream. Top level maps 1→Z and 0→0 on the open-drain AUD_PWM pin.
- sd_o  out  1  amplifier enable (AUD_SD)

## Operation
- States: IDLE and PLAY.
- IDLE → PLAY when start_i=1. On entry, the block latches:
  - hp = max(half_period_i, 1)
  - dur_cnt = duration_i
  - amp = amplitude_i
- Also on entry, it clears:
  - tick_cnt = 0
  - hp_cnt = 0
  - acc = 0
  - phase = 1
- start_i is ignored in PLAY. Inputs may change after acceptance without effect.
- In PLAY, tick_cnt counts 0..CLK_DIV-1 and wraps. A tick is the cycle where tick_cnt == CLK_DIV-1.
- On each tick when dur_cnt ≠ 0:
  - sample = phase ? amp : 0
  - sum[8:0] = acc + sample
  - pdm_o ← sum[8]
  - acc ← sum[7:0]
  - dur_cnt ← dur_cnt-1
  - if hp_cnt == hp-1, then hp_cnt ← 0 and phase toggles; otherwise hp_cnt increments.
- On a tick when dur_cnt == 0: PLAY → IDLE and done_o pulses. No bit is emitted on that tick.
- Result: exactly duration_i bits are produced, each held for exactly CLK_DIV cycles. The mean density during the high phase is amp/256.
- abort_i=1 in PLAY: go to IDLE on the next cycle, with no done_o pulse. abort_i in IDLE has no effect.
- Priority: rst_i > abort_i > tick completion.
- In IDLE, the following hold:
  - pdm_o=0 and sd_o=0
  - all counters are frozen
- In PLAY, sd_o=1.

## Timing
- Reset values: busy_o=0, done_o=0, pdm_o=0, sd_o=0, state IDLE, all counters and acc at 0.
- Reset asserted mid-play gives the same outputs on the next edge, with no done_o pulse.
- start_i sampled high at edge T (in IDLE):
  - busy_o=1 and sd_o=1 from T+1.
  - The first tick is at edge T+CLK_DIV, and the first bit is visible from T+CLK_DIV+1.
  - Bit k (1-based) is visible over cycles T+k·CLK_DIV+1 .. T+(k+1)·CLK_DIV.
- Completion: the state returns to IDLE at T+(N+1)·CLK_DIV+1, where N = duration_i. In that cycle:
  - done_o=1, for one cycle only
  - busy_o=0, sd_o=0, pdm_o=0
- Duration 0: done_o is high at T+CLK_DIV+1, and pdm_o stays 0 throughout.
- A new start_i is accepted in the same cycle done_o is high, because the state is already IDLE. Back-to-back tones therefore have a one-cycle sd_o gap.
- abort_i sampled high at edge A: at A+1, busy_o=0, sd_o=0, pdm_o=0, done_o=0.

## Test plan
All scenarios use CLK_DIV=4.
- Reset: assert rst_i for 2 cycles mid-play → all outputs 0 on the next cycle, no done_o pulse; a subsequent start_i is accepted normally.
- Full-scale square: amp=255, hp=2, dur=8 → pdm_o bits 0,1,0,0,1,1,0,0, each held 4 cycles. busy_o/sd_o high for 36 cycles; done_o pulses once at T+37.
- Half-scale constant: amp=128, hp=100, dur=8 → bits 0,1,0,1,0,1,0,1.
- Boundaries:
  - dur=0 → done_o at T+5 and pdm_o never 1.
  - hp=0 behaves as hp=1: amp=255, dur=4 → bits 0,0,1,0.
- Abort mid-tone at bit 3 → IDLE next cycle, no done_o. start_i held high during PLAY is ignored.
- Back-to-back: start_i asserted in the done_o cycle → second tone starts and busy_o drops for exactly that one cycle. Bit counts of both tones match their dur.
